// File: rtl/debouncer.sv
// Saturating-counter debouncer: debounce_out follows the input only after DEBOUNCE_CLKS
// consecutive mismatching clocks. Define DEBOUNCE_SYNC_EN to add a 2-flop input synchronizer.
module debouncer #(
  parameter int unsigned DEBOUNCE_CLKS = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic debounce_out
);

  localparam int unsigned CntW = (DEBOUNCE_CLKS < 1) ? 1 : $clog2(DEBOUNCE_CLKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CLKS - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CLKS);

  logic            sync2;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
    end
  end
`else
  // Input is already synchronous to clk in this build.
  assign sync2 = async_in;
`endif

  // Any matching clock discards the count, so runt pulses never accumulate.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (sync2 != out_q) begin
      if (cnt_q == CntLast) begin
        out_d = sync2;
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign debounce_out = out_q;

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: table-driven vectors on short-count instances plus
// long-count sequences on a default-parameter instance.
module tb_debouncer;

`ifdef DEBOUNCE_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif
  localparam int BigN = 10000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_big = 1'b0;
  logic in_small = 1'b0;
  logic out_big, out3, out1;

  always #5 clk = ~clk;

  debouncer #(.DEBOUNCE_CLKS(BigN)) dut_big (
    .clk(clk), .rst(rst), .async_in(in_big), .debounce_out(out_big)
  );
  debouncer #(.DEBOUNCE_CLKS(3)) dut3 (
    .clk(clk), .rst(rst), .async_in(in_small), .debounce_out(out3)
  );
  debouncer #(.DEBOUNCE_CLKS(1)) dut1 (
    .clk(clk), .rst(rst), .async_in(in_small), .debounce_out(out1)
  );

  typedef struct {
    logic in;
    logic exp3;
    logic exp1;
  } vec_t;

  vec_t tbl[16];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Cycles until out_big reaches target; -1 if the bound expires.
  task automatic wait_out(input logic target, input int maxc, output int n);
    n = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk);
      #1;
      if (out_big === target) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic hold_count(input int cyc, input logic val, output int bad);
    bad = 0;
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk);
      #1;
      if (out_big !== val) bad++;
    end
  endtask

  initial begin
    int n;
    int bad;
    int j;
    logic e3, e1;

    // N=3 expectations without synchronizer; N=1 simply follows the input.
    tbl[0]  = '{1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0};

    in_small = 1'b1;
    in_big   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_big", int'(out_big), 0);
    check("reset_out3", int'(out3), 0);
    check("reset_cnt_big", int'(dut_big.cnt_q), 0);
    in_small = 1'b0;
    in_big   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      in_small = tbl[i].in;
      @(posedge clk);
      #1;
      j  = i - Lat;
      e3 = (j >= 0) ? tbl[j].exp3 : 1'b0;
      e1 = (j >= 0) ? tbl[j].exp1 : 1'b0;
      check($sformatf("tbl%0d_out3", i), int'(out3), int'(e3));
      check($sformatf("tbl%0d_out1", i), int'(out1), int'(e1));
    end

    // Rise after exactly BigN mismatching clocks.
    in_big = 1'b1;
    wait_out(1'b1, BigN + 20, n);
    check("rise_latency", n, BigN + Lat);

    // Symmetric fall.
    in_big = 1'b0;
    wait_out(1'b0, BigN + 20, n);
    check("fall_latency", n, BigN + Lat);

    // One-clock runt must not move the output.
    in_big = 1'b1;
    @(posedge clk);
    #1;
    in_big = 1'b0;
    hold_count(10010, 1'b0, bad);
    check("runt_no_change", bad, 0);

    // Alternating mismatch/match never accumulates.
    for (int k = 0; k < 20010; k++) begin
      in_big = (k % 2 == 0) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      if (out_big !== 1'b0) bad++;
    end
    in_big = 1'b0;
    check("alternating_no_change", bad, 0);

    // Reset mid-count aborts the pending rise.
    in_big = 1'b1;
    repeat (5000) @(posedge clk);
    #1;
    check("precount_nonzero", int'(dut_big.cnt_q != 0), 1);
    #3;
    rst = 1'b0;
    #1;
    check("midreset_out", int'(out_big), 0);
    check("midreset_cnt", int'(dut_big.cnt_q), 0);
    in_big = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    hold_count(10010, 1'b0, bad);
    check("post_reset_low_no_change", bad, 0);

    // Release with input held high: full latency.
    rst = 1'b0;
    in_big = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_out(1'b1, BigN + 20, n);
    check("release_high_latency", n, BigN + Lat);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
